ps2_keyboard_receiver: RTL and testbench
========================================

// Module: ps2_keyboard_receiver
// PURPOSE
//  Producer side of the eLC-3 keyboard MMIO path. Deserialises PS/2 device-to-host frames into scan-code bytes.
//  Buffers the bytes in a FIFO and presents the head byte and a ready flag to the memory control unit.
//  The memory control unit reads KBDR, then pulses Read_Ack to pop one byte.
// PARAMETERS
//  FIFO_DEPTH      8        scan-code FIFO entries; power of two, >= 2
//  FILTER_LEN      8        consecutive equal Clk samples before the filtered PS2_CLK level changes
//  TIMEOUT_CYCLES  100000   Clk cycles with no filtered PS2_CLK falling edge before a partial frame is abandoned
// PORTS
//  Clk            in   1   system clock
//  Reset          in   1   asynchronous, active-high reset
//  PS2_CLK        in   1   raw PS/2 clock from keyboard (asynchronous, idle high)
//  PS2_DATA       in   1   raw PS/2 data from keyboard (asynchronous, idle high)
//  Read_Ack       in   1   one-cycle pulse: pop FIFO head (CPU consumed KBDR)
//  Clear_Err      in   1   one-cycle pulse: clear Overflow and Frame_Err
//  Data_ToMemCtl  out  16  {8'h00, FIFO head byte}; 16'h0000 when FIFO is empty
//  Ready          out  1   FIFO non-empty (drives KBSR[15])
//  Overflow       out  1   sticky: a good byte was dropped because the FIFO was full
//  Frame_Err      out  1   sticky: parity error, stop-bit error or timeout
// BEHAVIOUR
//  Reset (async, any time, including mid-frame):
//   - FSM to IDLE; FIFO emptied; bit and timeout counters cleared.
//   - Filtered clock and data levels set to 1.
//   - All outputs 0.
//  Input conditioning:
//   - PS2_CLK and PS2_DATA each pass through a 2-FF synchroniser.
//   - Filtered clock toggles only after FILTER_LEN consecutive samples at the new level.
//   - Fall = one-cycle pulse, registered, on a filtered 1->0 transition.
//   - Data is sampled on the synchronised PS2_DATA in the Fall cycle.
//  FSM; every transition is taken only on Fall:
//   - IDLE: data=0 (start bit) -> DATA, bit count=0; data=1 -> stay in IDLE, no error.
//   - DATA: shift data into the shift register LSB first; after 8 bits -> PARITY.
//   - PARITY: latch bit; parity is good when XOR of 8 data bits and parity bit = 1 (odd parity) -> STOP.
//   - STOP: stop=1 and parity good -> push byte, go IDLE.
//   - STOP: otherwise -> set Frame_Err, discard byte, go IDLE.
//  Timeout:
//   - Counter runs while FSM != IDLE and reloads on every Fall.
//   - When it reaches TIMEOUT_CYCLES: FSM -> IDLE, partial byte discarded, Frame_Err set.
//  FIFO:
//   - Push is registered: Ready and Data_ToMemCtl update on the Clk edge that ends the stop-bit Fall cycle.
//   - Read_Ack while empty is ignored.
//   - Read_Ack pops; the next entry (or 0 and Ready=0) is visible on the following edge.
//   - Push while full, with no same-cycle pop: byte dropped, Overflow set, FIFO contents unchanged.
//   - Simultaneous push and pop: both occur (when full, no overflow); occupancy unchanged.
//   - Pointers wrap modulo FIFO_DEPTH; occupancy count is log2(FIFO_DEPTH)+1 bits.
//  Error flags:
//   - Clear_Err clears both flags next edge.
//   - Set and Clear_Err in the same cycle: set wins.
//   - Errors never block reception of later frames.
// TESTING (bench: FILTER_LEN=4, TIMEOUT_CYCLES=200, PS/2 bit period 40 Clk)
//  1. Frame 0x1C, parity 0, stop 1 -> Ready=1, Data_ToMemCtl=16'h001C one edge after stop Fall.
//     Then Read_Ack -> Ready=0, Data=16'h0000.
//  2. Frames 0xF0 then 0x1C, no reads -> Data=16'h00F0.
//     Read_Ack -> Data=16'h001C, Ready=1.
//     Read_Ack -> Ready=0.
//  3. Frame 0x1C with parity bit 1 -> no push, Ready=0, Frame_Err=1.
//     Clear_Err -> Frame_Err=0.
//     Then a valid 0x32 frame is received normally.
//  4. Nine valid frames 0x01..0x09, no reads -> Overflow=1; eight pops return 0x01..0x08, then Ready=0.
//     Repeat with Read_Ack coincident with the 9th push -> Overflow=0.
//  5. Start bit plus 3 data bits, then the line is held idle for 250 cycles -> FSM IDLE and Frame_Err=1 by cycle 200.
//     The next 0x1C frame is received correctly.
//  6. 2-cycle low glitch on PS2_CLK while IDLE -> ignored.
//     Reset asserted mid-frame -> Ready=0, all flags 0, next frame received correctly.

Source files
------------

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 device-to-host receiver for the eLC-3 keyboard MMIO path.
// Conditions the raw PS/2 lines, decodes frames and queues scan codes.
module ps2_keyboard_receiver #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PS2_CLK,
  input  logic        PS2_DATA,
  input  logic        Read_Ack,
  input  logic        Clear_Err,
  output logic [15:0] Data_ToMemCtl,
  output logic        Ready,
  output logic        Overflow,
  output logic        Frame_Err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0]   C_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [FW-1:0] C_FLT  = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] C_TO   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_PAR, S_STOP
  } state_t;

  logic [1:0]    r_clk_s;
  logic [1:0]    r_dat_s;
  logic          r_clk_f;
  logic          r_clk_fd;
  logic [FW-1:0] r_flt_cnt;
  logic          r_fall;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;

  logic          w_bit;
  logic          w_par_ok;
  logic          w_timeout;
  logic          w_push;
  logic          w_ferr_set;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic          r_ferr;

  logic          w_pop;
  logic          w_full;
  logic          w_wr;
  logic          w_ovf_set;

  // Filtered clock only moves after FILTER_LEN agreeing samples
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_clk_s   <= 2'b11;
      r_dat_s   <= 2'b11;
      r_clk_f   <= 1'b1;
      r_clk_fd  <= 1'b1;
      r_flt_cnt <= '0;
      r_fall    <= 1'b0;
    end else begin
      r_clk_s <= {r_clk_s[0], PS2_CLK};
      r_dat_s <= {r_dat_s[0], PS2_DATA};
      if (r_clk_s[1] == r_clk_f) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == C_FLT) begin
        r_clk_f   <= r_clk_s[1];
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
      r_clk_fd <= r_clk_f;
      r_fall   <= r_clk_fd & ~r_clk_f;
    end
  end

  assign w_bit     = r_dat_s[1];
  assign w_timeout = (r_state != S_IDLE) && !r_fall
                  && (r_to_cnt == C_TO);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = S_IDLE;
    end else if (r_fall) begin
      unique case (r_state)
        S_IDLE: if (!w_bit) w_next = S_DATA;
        S_DATA: if (r_bit_cnt == 3'd7) w_next = S_PAR;
        S_PAR:  w_next = S_STOP;
        S_STOP: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_par_ok   = ^{r_shift, r_par};
    w_push     = 1'b0;
    w_ferr_set = w_timeout;
    if (r_fall && r_state == S_STOP) begin
      w_push     = w_bit & w_par_ok;
      w_ferr_set = ~(w_bit & w_par_ok);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (r_fall && r_state == S_IDLE) r_bit_cnt <= '0;
      if (r_fall && r_state == S_DATA) begin
        r_shift   <= {w_bit, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (r_fall && r_state == S_PAR) r_par <= w_bit;
      if (r_state == S_IDLE || r_fall) r_to_cnt <= '0;
      else                            r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_pop     = Read_Ack && (r_count != '0);
  assign w_full    = (r_count == C_FULL);
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_set = w_push && w_full && !w_pop;

  always_ff @(posedge Clk) begin
    if (w_wr) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      // A same-cycle set beats the clear
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (Clear_Err) r_ovf <= 1'b0;
      if (w_ferr_set)     r_ferr <= 1'b1;
      else if (Clear_Err) r_ferr <= 1'b0;
    end
  end

  assign Ready         = (r_count != '0);
  assign Data_ToMemCtl = Ready ? {8'h00, r_mem[r_rptr]} : 16'h0000;
  assign Overflow      = r_ovf;
  assign Frame_Err     = r_ferr;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed plus randomized bench for ps2_keyboard_receiver.
// A queue-based frame model supplies every expected value.
module tb_ps2_keyboard_receiver;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PS2_CLK = 1'b1;
  logic        PS2_DATA = 1'b1;
  logic        Read_Ack = 1'b0;
  logic        Clear_Err = 1'b0;
  logic [15:0] Data_ToMemCtl;
  logic        Ready;
  logic        Overflow;
  logic        Frame_Err;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  bit m_ovf = 1'b0;
  bit m_ferr = 1'b0;

  ps2_keyboard_receiver #(
    .FIFO_DEPTH(8),
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .PS2_CLK(PS2_CLK),
    .PS2_DATA(PS2_DATA),
    .Read_Ack(Read_Ack),
    .Clear_Err(Clear_Err),
    .Data_ToMemCtl(Data_ToMemCtl),
    .Ready(Ready),
    .Overflow(Overflow),
    .Frame_Err(Frame_Err)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [15:0] exp_d;
    exp_d = (q.size() != 0) ? {8'h00, q[0]} : 16'h0000;
    chk({tag, "_ready"}, 32'(Ready), 32'(q.size() != 0));
    chk({tag, "_data"}, 32'(Data_ToMemCtl), 32'(exp_d));
    chk({tag, "_ovf"}, 32'(Overflow), 32'(m_ovf));
    chk({tag, "_ferr"}, 32'(Frame_Err), 32'(m_ferr));
  endtask

  // One PS/2 bit: 40 Clk period, data set mid-high, ack placed in the push cycle
  task automatic drive_bit(input bit v, input bit ack, output int re);
    PS2_DATA = v;
    tick(10);
    PS2_CLK = 1'b0;
    re = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge Clk);
      #1;
      if (ack && e == 7) Read_Ack = 1'b1;
      if (ack && e == 8) Read_Ack = 1'b0;
      if (re < 0 && Ready) re = e;
    end
    PS2_CLK = 1'b1;
    tick(10);
  endtask

  task automatic model_frame(input logic [7:0] b, input bit p,
                             input bit s, input bit ack);
    if (s && (^{b, p})) begin
      if (ack && q.size() > 0) begin
        void'(q.pop_front());
        q.push_back(b);
      end else if (q.size() < 8) begin
        q.push_back(b);
      end else begin
        m_ovf = 1'b1;
      end
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit stop, input bit ack,
                            output int re);
    bit p;
    int dummy;
    p = (~^b) ^ bad_par;
    drive_bit(1'b0, 1'b0, dummy);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 1'b0, dummy);
    drive_bit(p, 1'b0, dummy);
    drive_bit(stop, ack, re);
    model_frame(b, p, stop, ack);
  endtask

  task automatic send_ok(input logic [7:0] b);
    int re;
    send_frame(b, 1'b0, 1'b1, 1'b0, re);
  endtask

  task automatic pop();
    Read_Ack = 1'b1;
    tick(1);
    Read_Ack = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic clr();
    Clear_Err = 1'b1;
    tick(1);
    Clear_Err = 1'b0;
    m_ovf = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    int re;
    int dummy;
    logic [7:0] rb;
    bit bad;
    bit stp;
    logic [7:0] pb;

    tick(3);
    chk_all("reset");
    Reset = 1'b0;
    tick(5);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, re);
    chk("t1_latency", 32'(re), 32'd8);
    chk_all("t1_rx");
    pop();
    chk_all("t1_pop");

    send_ok(8'hF0);
    send_ok(8'h1C);
    chk_all("t2_two");
    pop();
    chk_all("t2_pop1");
    pop();
    chk_all("t2_pop2");
    pop();
    chk_all("t2_pop_empty");

    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, re);
    chk_all("t3_badpar");
    clr();
    chk_all("t3_clr");
    send_ok(8'h32);
    chk_all("t3_rx32");
    pop();
    send_frame(8'h45, 1'b0, 1'b0, 1'b0, re);
    chk_all("t3_badstop");
    clr();

    for (int i = 1; i <= 9; i++) send_ok(8'(i));
    chk_all("t4_ovf");
    for (int i = 0; i < 8; i++) begin
      pop();
      chk_all($sformatf("t4_drain%0d", i));
    end
    clr();
    chk_all("t4_clr");
    for (int i = 1; i <= 8; i++) send_ok(8'(i));
    send_frame(8'h09, 1'b0, 1'b1, 1'b1, re);
    chk_all("t4_full_pushpop");
    for (int i = 0; i < 8; i++) begin
      pop();
      chk_all($sformatf("t4_drainb%0d", i));
    end

    drive_bit(1'b0, 1'b0, dummy);
    drive_bit(1'b1, 1'b0, dummy);
    drive_bit(1'b0, 1'b0, dummy);
    drive_bit(1'b1, 1'b0, dummy);
    tick(120);
    chk_all("t5_before_to");
    tick(130);
    m_ferr = 1'b1;
    chk_all("t5_timeout");
    clr();
    send_ok(8'h1C);
    chk_all("t5_after");
    pop();

    PS2_DATA = 1'b0;
    PS2_CLK = 1'b0;
    tick(2);
    PS2_CLK = 1'b1;
    PS2_DATA = 1'b1;
    tick(20);
    send_ok(8'h1C);
    chk_all("t6_glitch");
    send_frame(8'h22, 1'b1, 1'b1, 1'b0, re);
    for (int i = 1; i <= 8; i++) send_ok(8'(8'h30 + i));
    chk_all("t6_prereset");
    drive_bit(1'b0, 1'b0, dummy);
    drive_bit(1'b1, 1'b0, dummy);
    drive_bit(1'b1, 1'b0, dummy);
    Reset = 1'b1;
    #2;
    q.delete();
    m_ovf = 1'b0;
    m_ferr = 1'b0;
    chk_all("t6_async_rst");
    tick(2);
    Reset = 1'b0;
    tick(3);
    send_ok(8'h1C);
    chk_all("t6_post_rst");
    pop();

    for (int n = 0; n < 16; n++) begin
      rb  = 8'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 7) != 0);
      send_frame(rb, bad, stp, 1'b0, re);
      chk_all($sformatf("rnd%0d_rx", n));
      repeat ($urandom_range(0, 2)) begin
        pop();
        chk_all($sformatf("rnd%0d_pop", n));
      end
      if ($urandom_range(0, 1) == 1) begin
        clr();
        chk_all($sformatf("rnd%0d_clr", n));
      end
    end

    pb = 8'h5A;
    send_ok(pb);
    chk_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
